var_delay: RTL

VAR_DELAY -- requirements
Module: var_delay

---
 rtl/var_delay.sv | 113 +++++++++++
 1 files changed

// File: rtl/var_delay.sv
// -----------------------------------------------------------------------------
// var_delay -- run-time selectable delay line for data words.
//
// Each enabled clock edge writes d_in into a circular buffer. d_out is
// registered and shows the word written (D_act-1) enabled edges earlier. A
// delay of 1 bypasses the buffer and behaves as a single register. d_out shows
// DEFAULT until the fill counter reaches D_act. A change of the requested delay
// refills the line, so no word from before the change reaches d_out.
//
// Ports
//   clk        sole clock, rising edge
//   reset_n    asynchronous active-low reset of pointer, fill, D_act, outputs
//   en         sample strobe; all state holds on edges with en=0
//   delay_sel  requested delay in enabled cycles (0 -> 1, >MAX_DELAY -> MAX)
//   d_in       input data word
//   d_out      delayed data word (registered), DEFAULT while not primed
//   primed     high when d_out carries delayed data
// -----------------------------------------------------------------------------
module var_delay #(
   parameter int   BITS      = 56,
   parameter int   MAX_DELAY = 16,
   parameter logic DEFAULT   = 1'b0,
   localparam int  DW        = $clog2(MAX_DELAY + 1)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            en,
   input  logic [DW-1:0]   delay_sel,
   input  logic [BITS-1:0] d_in,
   output logic [BITS-1:0] d_out,
   output logic            primed
);

   localparam int PW = $clog2(MAX_DELAY);
   // Wide enough to hold wp + MAX_DELAY before the modulo step.
   localparam int AW = $clog2(2 * MAX_DELAY);
   localparam logic [DW-1:0]   MAX_D   = DW'(MAX_DELAY);
   localparam logic [DW-1:0]   ONE_D   = DW'(1);
   localparam logic [BITS-1:0] DEF_WORD = {BITS{DEFAULT}};

   logic [BITS-1:0] mem [MAX_DELAY];
   logic [PW-1:0]   wp;
   logic [DW-1:0]   fill;
   logic [DW-1:0]   d_act;

   logic [DW-1:0]   d_eff;
   logic            chg;
   logic [PW-1:0]   wp_next;
   logic [AW-1:0]   rd_sum;
   logic [AW-1:0]   rd_mod;
   logic [PW-1:0]   rd_addr;
   logic [DW-1:0]   fill_next;
   logic            primed_next;
   logic [BITS-1:0] rd_word;

   function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] sel);
      if (sel == '0)
         return ONE_D;
      else if (sel > MAX_D)
         return MAX_D;
      else
         return sel;
   endfunction

   always_comb begin
      d_eff   = clamp_delay(delay_sel);
      chg     = (d_eff != d_act);
      wp_next = (wp == PW'(MAX_DELAY - 1)) ? '0 : wp + PW'(1);

      // Word written D_act-1 enabled edges ago: (wp - (D_act-1)) mod MAX_DELAY,
      // formed as wp + MAX_DELAY - D_act + 1 so it never goes negative.
      rd_sum  = AW'(wp) + AW'(MAX_DELAY) - AW'(d_act) + AW'(1);
      rd_mod  = (rd_sum >= AW'(MAX_DELAY)) ? rd_sum - AW'(MAX_DELAY) : rd_sum;
      rd_addr = PW'(rd_mod);

      // The delay-1 case reads the word being written this edge.
      rd_word = (d_act == ONE_D) ? d_in : mem[rd_addr];

      fill_next   = (fill < d_act) ? fill + ONE_D : fill;
      primed_next = (fill_next >= d_act);
   end

   // Buffer storage: written on every enabled edge, never reset.
   always_ff @(posedge clk) begin
      if (en)
         mem[wp] <= d_in;
   end

   // Output stage: pointer, fill counter, active delay and registered output.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wp     <= '0;
         fill   <= '0;
         d_act  <= ONE_D;
         primed <= 1'b0;
         d_out  <= DEF_WORD;
      end else if (en) begin
         wp <= wp_next;
         if (chg) begin
            // Delay change: restart filling; this edge's write counts as one.
            d_act  <= d_eff;
            fill   <= ONE_D;
            primed <= 1'b0;
            d_out  <= DEF_WORD;
         end else begin
            fill   <= fill_next;
            primed <= primed_next;
            d_out  <= primed_next ? rd_word : DEF_WORD;
         end
      end
   end

endmodule
